load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the RV32I core.
- Takes the ALU-computed effective address plus the rs2 store data and the instruction funct3, and runs a request/grant/response transaction on the data-memory port.
- Returns sign- or zero-extended load data, or a store completion, to writeback.
- Detects misaligned accesses, illegal funct3 values and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 16, max cycles spent in REQ+WAIT before aborting with a bus-timeout error; legal range 2..255
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core presents a load/store
req_ready  out  1  unit can accept a request
req_is_store  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  32  effective address from ALU result
req_wdata  in  32  rs2 store data
mem_req  out  1  memory request valid
mem_we  out  1  write enable
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  memory accepts the current request
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data word
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load result; 0 for stores and errors
rsp_err  out  1  access failed
rsp_cause  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, counter=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_cause=00.
  - req_ready=1 once reset is released.
- Reset mid-transaction aborts immediately. No response is ever produced for the aborted request.
- All outputs are registered except req_ready, which is 1 iff state==IDLE.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: a request is accepted when req_valid&&req_ready. On acceptance, latch addr[1:0], funct3 and is_store, and decode:
  - Illegal funct3 → RESP with cause 11. Illegal loads: 011, 110, 111. Illegal stores: anything other than 000, 001, 010.
  - Misaligned → RESP with cause 01. Halfword with addr[0]=1; word with addr[1:0]!=0.
  - Otherwise → REQ, and drive mem_req/mem_we/mem_addr/mem_be/mem_wdata from the next cycle.
  - Error paths never assert mem_req.
- Byte enables:
  - Byte access: be = 4'b0001 << addr[1:0].
  - Halfword: addr[1]=0 → 0011, addr[1]=1 → 1100.
  - Word: 1111.
  - Loads drive the same be pattern.
- Store data replication: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- REQ:
  - mem_req=1 and all mem_* signals are held stable until mem_gnt=1.
  - On gnt, mem_req drops the next cycle. Store → RESP; load → WAIT.
- WAIT:
  - mem_rvalid is sampled only in this state; rvalid asserted during REQ is ignored.
  - On rvalid, extract by addr[1:0], capture into rsp_rdata, → RESP.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Timeout:
  - Counter clears on acceptance and increments each cycle spent in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES without gnt (REQ) or rvalid (WAIT) → drop mem_req, → RESP with cause 10.
  - If gnt/rvalid arrives in the same cycle the limit is hit, the gnt/rvalid wins.
- RESP: rsp_valid=1 for exactly one cycle, then → IDLE. A new request can be accepted the following cycle.
- Latency from the acceptance cycle, with zero-wait memory:
  - Store: rsp_valid at acceptance+2.
  - Load: rsp_valid at acceptance+3.
  - Error at decode: rsp_valid at acceptance+1.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt in first REQ cycle → mem_addr=0x100, be=1111, we=1, wdata=0xDEADBEEF; rsp_valid 2 cycles after acceptance with err=0, rdata=0.
- LB addr=0x103, mem_rdata=0x80112233 → be=1000; rsp_rdata=0xFFFFFF80. Repeat as LBU → 0x00000080.
- SH addr=0x202, wdata=0x0000ABCD → mem_addr=0x200, be=1100, mem_wdata=0xABCDABCD. LHU addr=0x202, rdata=0xABCD1234 → 0x0000ABCD.
- LW addr=0x101 → no mem_req ever; rsp_valid next cycle, err=1, cause=01. Load funct3=011 → cause=11.
- LW with gnt held low 16 cycles (TIMEOUT_CYCLES=16) → mem_req drops, rsp err=1 cause=10. Repeat with gnt arriving exactly on cycle 16 → normal completion.
- Assert rst_n=0 while in WAIT → all outputs 0 immediately; a later rvalid produces no rsp_valid; the next request completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory port of the load/store unit.
// master = the load/store unit, slave = core + memory environment.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [1:0]  rsp_cause;

   modport master (
      input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output req_ready,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output rsp_valid, rsp_rdata, rsp_err, rsp_cause
   );

   modport slave (
      output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  req_ready,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_cause
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes a memory op, runs req/gnt/rvalid on the data
// port, and returns an extended load result or error to writeback.
//
// state  | meaning
// IDLE   | ready for a new request (req_ready=1)
// REQ    | mem_req held with stable address/be/data until mem_gnt
// WAIT   | load granted, waiting for mem_rvalid
// RESP   | rsp_valid pulse for one cycle
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 8
) (
   input logic              clk,
   input logic              rst_n,
   load_store_unit_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             cnt_expired;
   logic [1:0]       addr_lo;
   logic [2:0]       funct3_q;
   logic             is_store_q;

   logic             dec_illegal;
   logic             dec_misaligned;
   logic [3:0]       dec_be;
   logic [31:0]      dec_wdata;

   logic [31:0]      rd_shift;
   logic [15:0]      rd_half;
   logic [31:0]      ld_data;

   assign bus.req_ready = (state == S_IDLE);
   assign cnt_inc       = cnt + CNT_W'(1);
   assign cnt_expired   = (cnt_inc == CNT_LIM);

   always_comb begin
      dec_illegal    = 1'b0;
      dec_misaligned = 1'b0;
      dec_be         = 4'b1111;
      dec_wdata      = bus.req_wdata;
      if (bus.req_is_store)
         dec_illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
      else
         dec_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                       (bus.req_funct3 == 3'b111);
      case (bus.req_funct3[1:0])
         2'b00: begin
            dec_be    = 4'b0001 << bus.req_addr[1:0];
            dec_wdata = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            dec_be         = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            dec_wdata      = {2{bus.req_wdata[15:0]}};
            dec_misaligned = bus.req_addr[0];
         end
         default: begin
            dec_misaligned = |bus.req_addr[1:0];
         end
      endcase
   end

   always_comb begin
      rd_shift = bus.mem_rdata >> {addr_lo, 3'b000};
      rd_half  = addr_lo[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (funct3_q)
         3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
         3'b100:  ld_data = {24'd0, rd_shift[7:0]};
         3'b101:  ld_data = {16'd0, rd_half};
         default: ld_data = bus.mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         addr_lo       <= 2'b00;
         funct3_q      <= 3'b000;
         is_store_q    <= 1'b0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= 32'd0;
         bus.mem_be    <= 4'd0;
         bus.mem_wdata <= 32'd0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= 32'd0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_cause <= 2'b00;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  addr_lo    <= bus.req_addr[1:0];
                  funct3_q   <= bus.req_funct3;
                  is_store_q <= bus.req_is_store;
                  cnt        <= '0;
                  if (dec_illegal || dec_misaligned) begin
                     state         <= S_RESP;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_cause <= dec_illegal ? 2'b11 : 2'b01;
                  end else begin
                     state         <= S_REQ;
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= bus.req_is_store;
                     bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                     bus.mem_be    <= dec_be;
                     bus.mem_wdata <= bus.req_is_store ? dec_wdata : 32'd0;
                  end
               end
            end
            S_REQ: begin
               cnt <= cnt_inc;
               // A grant on the limit cycle still counts as a grant.
               if (bus.mem_gnt || cnt_expired) begin
                  bus.mem_req   <= 1'b0;
                  bus.mem_we    <= 1'b0;
                  bus.mem_addr  <= 32'd0;
                  bus.mem_be    <= 4'd0;
                  bus.mem_wdata <= 32'd0;
               end
               if (bus.mem_gnt) begin
                  if (is_store_q) begin
                     state         <= S_RESP;
                     bus.rsp_valid <= 1'b1;
                  end else begin
                     state <= S_WAIT;
                  end
               end else if (cnt_expired) begin
                  state         <= S_RESP;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_cause <= 2'b10;
               end
            end
            S_WAIT: begin
               cnt <= cnt_inc;
               if (bus.mem_rvalid) begin
                  state         <= S_RESP;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_rdata <= ld_data;
               end else if (cnt_expired) begin
                  state         <= S_RESP;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_cause <= 2'b10;
               end
            end
            default: begin
               state         <= S_IDLE;
               bus.rsp_valid <= 1'b0;
               bus.rsp_rdata <= 32'd0;
               bus.rsp_err   <= 1'b0;
               bus.rsp_cause <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random
// transactions compared against a byte-lane arithmetic reference model.
module tb_load_store_unit;

   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;

   load_store_unit_if bus ();

   load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one request and follows it to completion; gnt_dly/rv_dly are the
   // number of idle cycles memory inserts before gnt/rvalid.
   task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rd);
      int          nb, t, w, bei, lane;
      bit          illegal, mis, in_wait, done, tout, ev;
      logic [3:0]  be;
      logic [31:0] rep, ld, mask, exp_rd;
      illegal = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      nb      = 1 << f3[1:0];
      lane    = int'(a[1:0]);
      mis     = !illegal && ((lane % nb) != 0);
      bei     = ((1 << nb) - 1) << lane;
      be      = bei[3:0];
      for (int i = 0; i < 4; i++) rep[8*i +: 8] = wd[8*(i % nb) +: 8];
      ld = rd >> (8 * lane);
      if (nb < 4) begin
         mask = (32'd1 << (8 * nb)) - 32'd1;
         ld   = ld & mask;
         if (!f3[2] && ld[8*nb-1]) ld = ld | ~mask;
      end

      chk("req_ready_idle", bus.req_ready, 1'b1);
      bus.req_valid    = 1'b1;
      bus.req_is_store = st;
      bus.req_funct3   = f3;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
      step();
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;

      if (illegal || mis) begin
         chk("err_no_memreq", bus.mem_req, 1'b0);
         chk("err_rsp_valid", bus.rsp_valid, 1'b1);
         chk("err_rsp_err", bus.rsp_err, 1'b1);
         chk("err_rsp_cause", bus.rsp_cause, illegal ? 2'b11 : 2'b01);
         chk("err_rsp_rdata", bus.rsp_rdata, 32'd0);
         step();
         chk("err_rsp_done", bus.rsp_valid, 1'b0);
         chk("err_no_memreq2", bus.mem_req, 1'b0);
         chk("err_ready_back", bus.req_ready, 1'b1);
         return;
      end

      t = 0; w = 0; in_wait = 0; done = 0; tout = 0;
      while (!done) begin
         chk("busy_ready", bus.req_ready, 1'b0);
         chk("busy_rsp_valid", bus.rsp_valid, 1'b0);
         if (!in_wait) begin
            chk("mem_req", bus.mem_req, 1'b1);
            chk("mem_we", bus.mem_we, st);
            chk("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
            chk("mem_be", bus.mem_be, be);
            chk("mem_wdata", bus.mem_wdata, st ? rep : 32'd0);
            bus.mem_gnt    = (t >= gnt_dly);
            bus.mem_rvalid = 1'($urandom_range(0, 1));
            bus.mem_rdata  = $urandom;
            ev = bus.mem_gnt;
         end else begin
            chk("wait_mem_req", bus.mem_req, 1'b0);
            bus.mem_rvalid = (w >= rv_dly);
            bus.mem_rdata  = bus.mem_rvalid ? rd : $urandom;
            ev = bus.mem_rvalid;
            w++;
         end
         t++;
         step();
         bus.mem_gnt    = 1'b0;
         bus.mem_rvalid = 1'b0;
         if (ev) begin
            if (!in_wait && !st) in_wait = 1;
            else done = 1;
         end else if (t == TO) begin
            done = 1;
            tout = 1;
         end
      end

      exp_rd = (tout || st) ? 32'd0 : ld;
      chk("rsp_mem_req", bus.mem_req, 1'b0);
      chk("rsp_valid", bus.rsp_valid, 1'b1);
      chk("rsp_err", bus.rsp_err, tout);
      chk("rsp_cause", bus.rsp_cause, tout ? 2'b10 : 2'b00);
      chk("rsp_rdata", bus.rsp_rdata, exp_rd);
      step();
      chk("rsp_done", bus.rsp_valid, 1'b0);
      chk("ready_back", bus.req_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          st;
      logic [2:0]  f3;
      logic [31:0] a;
      int          gd;
      logic [2:0]  legal_ld [5];
      legal_ld = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

      bus.req_valid = 0; bus.req_is_store = 0; bus.req_funct3 = 0;
      bus.req_addr = 0; bus.req_wdata = 0;
      bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", bus.mem_req, 1'b0);
      chk("rst_mem_we", bus.mem_we, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_be", bus.mem_be, 4'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_rsp_err", bus.rsp_err, 1'b0);
      chk("rst_rsp_cause", bus.rsp_cause, 2'b00);
      rst_n = 1'b1;
      step();
      chk("rst_ready", bus.req_ready, 1'b1);

      // Directed cases
      run_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
      run_txn(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80112233);
      run_txn(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80112233);
      run_txn(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 0, 0, 32'h0);
      run_txn(1'b0, 3'b101, 32'h202, 32'h0, 0, 0, 32'hABCD1234);
      run_txn(1'b0, 3'b001, 32'h202, 32'h0, 1, 2, 32'h8001F234);
      run_txn(1'b1, 3'b000, 32'h301, 32'h000000A5, 2, 0, 32'h0);
      run_txn(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0);
      run_txn(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0);
      run_txn(1'b1, 3'b100, 32'h100, 32'h0, 0, 0, 32'h0);
      run_txn(1'b1, 3'b001, 32'h103, 32'h0, 0, 0, 32'h0);
      run_txn(1'b0, 3'b010, 32'h400, 32'h0, TO, 0, 32'h0);
      run_txn(1'b0, 3'b010, 32'h400, 32'h0, TO - 1, 0, 32'h0);
      run_txn(1'b1, 3'b010, 32'h404, 32'h12345678, TO - 1, 0, 32'h0);
      run_txn(1'b0, 3'b010, 32'h408, 32'h0, 5, 20, 32'h0);
      run_txn(1'b0, 3'b010, 32'h40C, 32'h0, 5, TO - 7, 32'hCAFEF00D);

      // Reset while waiting for read data
      bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h40;
      step();
      bus.req_valid = 1'b0;
      bus.mem_gnt = 1'b1;
      step();
      bus.mem_gnt = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_mem_req", bus.mem_req, 1'b0);
      chk("midrst_mem_addr", bus.mem_addr, 32'd0);
      chk("midrst_mem_be", bus.mem_be, 4'd0);
      chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("midrst_rsp_err", bus.rsp_err, 1'b0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = 32'h55AA55AA;
         step();
         chk("midrst_no_rsp", bus.rsp_valid, 1'b0);
      end
      bus.mem_rvalid = 1'b0;
      run_txn(1'b0, 3'b010, 32'h44, 32'h0, 0, 1, 32'h0BADF00D);

      // Random transactions
      for (int n = 0; n < 80; n++) begin
         st = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) < 8)
            f3 = st ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
         else
            f3 = 3'($urandom_range(0, 7));
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
         if ($urandom_range(0, 3) == 0) a[1] = 1'b0;
         gd = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 3);
         run_txn(st, f3, a, $urandom, gd, $urandom_range(0, 4), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
